// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and the fftshift address helper for the FFT result reader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   N_PT, LOG2_N, DW  - symbol length, address width, default sample width
//   fft_state_t       - reader FSM encoding (IDLE / CAPTURE / STREAM)
//   stream_addr()     - maps output position k to buffer address, optionally DC-centred
package fft_pkg;

    localparam int N_PT   = 64;
    localparam int LOG2_N = 6;
    localparam int DW     = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_STREAM  = 2'd2
    } fft_state_t;

    // A half-symbol rotation is just a flip of the address MSB.
    function automatic logic [LOG2_N-1:0] stream_addr(
        input logic [LOG2_N-1:0] k,
        input logic              shift
    );
        return {k[LOG2_N-1] ^ shift, k[LOG2_N-2:0]};
    endfunction

endpackage

// File: rtl/fft_sample_buf.sv
// One-symbol complex sample store: single write port, single combinational read port.
// Latency: write lands on the clock edge; read data is combinational from i_raddr.
// Backpressure: none; the owner decides when to write and what to read.
//
// Ports:
//   clk            - clock (rising edge)
//   i_we           - write enable
//   i_waddr        - write address (0..63)
//   i_wdat         - write data {re, im}
//   i_raddr        - read address (0..63)
//   o_rdat         - read data {re, im}
module fft_sample_buf #(
    parameter int DW = 16
) (
    input  logic                        clk,
    input  logic                        i_we,
    input  logic [fft_pkg::LOG2_N-1:0]  i_waddr,
    input  logic [2*DW-1:0]             i_wdat,
    input  logic [fft_pkg::LOG2_N-1:0]  i_raddr,
    output logic [2*DW-1:0]             o_rdat
);
    import fft_pkg::*;

    // Contents are deliberately not reset: the reader never emits an entry
    // before it has been overwritten by a fresh capture.
    logic [2*DW-1:0] r_mem [0:N_PT-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/fft_result_reader.sv
// Copies one 64-point FFT result bank into a local buffer, then streams it out in natural or DC-centred order.
// Latency: first o_valid 64 cycles after the accepted i_fft_done; one beat per cycle while i_ready is high.
// Backpressure: valid/ready on the output; beat held stable while stalled; done pulses while busy are counted as drops.
//
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   i_fft_done                      - FFT bank ready pulse
//   o_fft_read_addr                 - FFT read address (combinational)
//   i_fft_read_re / i_fft_read_im   - FFT read data for o_fft_read_addr
//   i_fftshift                      - DC-centred order, latched when a capture starts
//   o_valid / i_ready               - output stream handshake
//   o_re / o_im / o_index / o_last  - output beat
//   o_busy                          - reader not idle
//   o_drop_cnt                      - saturating count of ignored done pulses
module fft_result_reader #(
    parameter int N_PT = fft_pkg::N_PT,
    parameter int DW   = fft_pkg::DW
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_fft_done,
    output logic [fft_pkg::LOG2_N-1:0]  o_fft_read_addr,
    input  logic signed [DW-1:0]        i_fft_read_re,
    input  logic signed [DW-1:0]        i_fft_read_im,
    input  logic                        i_fftshift,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic signed [DW-1:0]        o_re,
    output logic signed [DW-1:0]        o_im,
    output logic [fft_pkg::LOG2_N-1:0]  o_index,
    output logic                        o_last,
    output logic                        o_busy,
    output logic [7:0]                  o_drop_cnt
);
    import fft_pkg::*;

    localparam logic [LOG2_N-1:0] LP_LAST = LOG2_N'(N_PT - 1);
    localparam logic [LOG2_N-1:0] LP_ZERO = '0;
    localparam logic [LOG2_N-1:0] LP_ONE  = LOG2_N'(1);

    fft_state_t         r_state;
    logic [LOG2_N-1:0]  r_cnt;
    logic [LOG2_N-1:0]  r_k;
    logic               r_shift;
    logic               r_valid;
    logic               r_last;
    logic signed [DW-1:0] r_re;
    logic signed [DW-1:0] r_im;
    logic [7:0]         r_drop_cnt;

    logic               w_hs;
    logic               w_final_hs;
    logic               w_accept;
    logic               w_drop;
    logic               w_we;
    logic [LOG2_N-1:0]  w_k_next;
    logic [LOG2_N-1:0]  w_rd_addr;
    logic [2*DW-1:0]    w_rd_dat;

    assign w_hs       = r_valid && i_ready;
    assign w_final_hs = w_hs && r_last;

    // A done pulse is taken when idle, or when it lands exactly on the last
    // handshake so back-to-back symbols lose no cycles; anything else is a drop.
    assign w_accept = i_fft_done && ((r_state == ST_IDLE) || w_final_hs);
    assign w_drop   = i_fft_done && !w_accept;

    // r_cnt sits at 0 outside CAPTURE, so the FFT sees address 0 in the done
    // cycle both from IDLE and on a back-to-back accept from STREAM.
    assign o_fft_read_addr = (r_state == ST_IDLE) ? LP_ZERO : r_cnt;

    assign w_we = !rst && (w_accept || (r_state == ST_CAPTURE));

    // Outputs are registered, so the buffer is read one beat ahead: the first
    // beat is fetched during the final capture cycle, later beats at handshake.
    assign w_k_next  = r_k + LP_ONE;
    assign w_rd_addr = (r_state == ST_STREAM) ? stream_addr(w_k_next, r_shift)
                                              : stream_addr(LP_ZERO, r_shift);

    fft_sample_buf #(
        .DW (DW)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (o_fft_read_addr),
        .i_wdat  ({i_fft_read_re, i_fft_read_im}),
        .i_raddr (w_rd_addr),
        .o_rdat  (w_rd_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= LP_ZERO;
            r_k        <= LP_ZERO;
            r_shift    <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_re       <= '0;
            r_im       <= '0;
            r_drop_cnt <= 8'd0;
        end else begin
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_fft_done) begin
                        r_state <= ST_CAPTURE;
                        r_cnt   <= LP_ONE;
                        r_shift <= i_fftshift;
                    end
                end

                ST_CAPTURE: begin
                    // Wraps to 0 after entry 63, leaving the address at 0 for STREAM.
                    r_cnt <= r_cnt + LP_ONE;
                    if (r_cnt == LP_LAST) begin
                        r_state <= ST_STREAM;
                        r_k     <= LP_ZERO;
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                        r_re    <= $signed(w_rd_dat[2*DW-1:DW]);
                        r_im    <= $signed(w_rd_dat[DW-1:0]);
                    end
                end

                ST_STREAM: begin
                    if (w_hs) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_k     <= LP_ZERO;
                            r_re    <= '0;
                            r_im    <= '0;
                            if (i_fft_done) begin
                                r_state <= ST_CAPTURE;
                                r_cnt   <= LP_ONE;
                                r_shift <= i_fftshift;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_k    <= w_k_next;
                            r_last <= (w_k_next == LP_LAST);
                            r_re   <= $signed(w_rd_dat[2*DW-1:DW]);
                            r_im   <= $signed(w_rd_dat[DW-1:0]);
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= LP_ZERO;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid    = r_valid;
    assign o_last     = r_last;
    assign o_index    = r_k;
    assign o_re       = r_re;
    assign o_im       = r_im;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_fft_result_reader.sv
// Randomised bench for fft_result_reader against a bank/queue reference model.
// Latency: checks first beat 64 cycles after done and one beat per handshake.
// Backpressure: drives random and stuck-low ready, checks beat stability while stalled.
module tb_fft_result_reader;

    logic               clk;
    logic               rst;
    logic               i_fft_done;
    logic [5:0]         o_fft_read_addr;
    logic signed [15:0] i_fft_read_re;
    logic signed [15:0] i_fft_read_im;
    logic               i_fftshift;
    logic               o_valid;
    logic               i_ready;
    logic signed [15:0] o_re;
    logic signed [15:0] o_im;
    logic [5:0]         o_index;
    logic               o_last;
    logic               o_busy;
    logic [7:0]         o_drop_cnt;

    fft_result_reader #(.N_PT(64), .DW(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_fft_done      (i_fft_done),
        .o_fft_read_addr (o_fft_read_addr),
        .i_fft_read_re   (i_fft_read_re),
        .i_fft_read_im   (i_fft_read_im),
        .i_fftshift      (i_fftshift),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_re            (o_re),
        .o_im            (o_im),
        .o_index         (o_index),
        .o_last          (o_last),
        .o_busy          (o_busy),
        .o_drop_cnt      (o_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FFT core model: the current result bank, read combinationally.
    logic signed [15:0] bank_re [64];
    logic signed [15:0] bank_im [64];
    assign i_fft_read_re = bank_re[o_fft_read_addr];
    assign i_fft_read_im = bank_im[o_fft_read_addr];

    typedef struct {
        int re;
        int im;
        int idx;
    } beat_t;

    beat_t exp_q[$];
    int    exp_drop;
    int    n_chk;
    int    n_pass;
    int    ready_mode;   // 0 always ready, 1 random, 2 never ready

    task automatic chk(input string tag, input longint obs, input longint exp_v);
        n_chk++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ramp();
        for (int n = 0; n < 64; n++) begin
            bank_re[n] = 16'(n);
            bank_im[n] = 16'(-n);
        end
    endtask

    task automatic fill_random();
        for (int n = 0; n < 64; n++) begin
            bank_re[n] = 16'($urandom);
            bank_im[n] = 16'($urandom);
        end
    endtask

    // Expected beats for the current bank: natural order, or rotated by half
    // a symbol so the DC bin lands in the middle.
    task automatic push_symbol(input bit sh);
        beat_t b;
        for (int k = 0; k < 64; k++) begin
            int src;
            src   = sh ? (k + 32) % 64 : k;
            b.re  = int'(bank_re[src]);
            b.im  = int'(bank_im[src]);
            b.idx = k;
            exp_q.push_back(b);
        end
    endtask

    function automatic int sat_inc(input int v, input int by);
        return (v + by > 255) ? 255 : v + by;
    endfunction

    // Called at posedge+1 with the DUT idle; leaves done low after one edge.
    task automatic start_capture(input bit sh);
        i_fftshift = sh;
        i_fft_done = 1'b1;
        chk("addr_at_done", o_fft_read_addr, 0);
        push_symbol(sh);
        step();
        i_fft_done = 1'b0;
        chk("busy_after_done", o_busy, 1);
        chk("addr_after_done", o_fft_read_addr, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < budget) begin
            step();
            n++;
        end
        chk("idle_timeout", (n < budget) ? 1 : 0, 1);
        chk("drop_cnt", o_drop_cnt, exp_drop);
    endtask

    task automatic wait_beat(input int idx, input int budget);
        int n;
        n = 0;
        while (!(o_valid && o_index == 6'(idx)) && n < budget) begin
            step();
            n++;
        end
        chk("beat_timeout", (n < budget) ? 1 : 0, 1);
    endtask

    // Ready driver.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = 1'($urandom_range(0, 1));
            default: i_ready = 1'b0;
        endcase
    end

    // Stream monitor: compare every handshake with the model, and check that
    // a stalled beat does not change.
    bit                 prev_stall;
    logic signed [15:0] prev_re;
    logic signed [15:0] prev_im;
    logic [5:0]         prev_idx;
    logic               prev_last;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && o_valid) begin
                chk("hold_re", o_re, prev_re);
                chk("hold_im", o_im, prev_im);
                chk("hold_idx", o_index, prev_idx);
                chk("hold_last", o_last, prev_last);
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", o_index, -1);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_re", o_re, e.re);
                    chk("beat_im", o_im, e.im);
                    chk("beat_idx", o_index, e.idx);
                    chk("beat_last", o_last, (e.idx == 63) ? 1 : 0);
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_re    = o_re;
            prev_im    = o_im;
            prev_idx   = o_index;
            prev_last  = o_last;
        end
    end

    initial begin
        int lat;
        n_chk      = 0;
        n_pass     = 0;
        exp_drop   = 0;
        ready_mode = 0;
        rst        = 1'b1;
        i_fft_done = 1'b0;
        i_fftshift = 1'b0;
        i_ready    = 1'b1;
        prev_stall = 1'b0;
        fill_ramp();
        repeat (3) step();
        rst = 1'b0;

        // Reset state.
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_last", o_last, 0);
        chk("rst_index", o_index, 0);
        chk("rst_re", o_re, 0);
        chk("rst_im", o_im, 0);
        chk("rst_addr", o_fft_read_addr, 0);
        chk("rst_drop", o_drop_cnt, 0);
        step();

        // Ramp, natural order, always ready; measure first-beat latency.
        start_capture(1'b0);
        lat = 1;
        while (!o_valid && lat < 200) begin
            step();
            lat++;
        end
        chk("first_valid_lat", lat, 64);
        wait_idle(400);

        // Ramp, DC-centred order.
        start_capture(1'b1);
        wait_idle(400);

        // Random data and order under random stalls.
        for (int s = 0; s < 3; s++) begin
            ready_mode = 1;
            fill_random();
            start_capture(1'($urandom_range(0, 1)));
            wait_idle(2000);
        end
        ready_mode = 0;
        step();

        // Done pulses while capturing and while streaming are dropped.
        fill_random();
        start_capture(1'b0);
        repeat (19) step();
        i_fft_done = 1'b1;
        exp_drop   = sat_inc(exp_drop, 1);
        step();
        i_fft_done = 1'b0;
        wait_beat(5, 200);
        i_fft_done = 1'b1;
        exp_drop   = sat_inc(exp_drop, 1);
        step();
        i_fft_done = 1'b0;
        wait_idle(400);

        // Done on the final handshake starts the next capture with no gap.
        fill_random();
        start_capture(1'b1);
        wait_beat(63, 400);
        fill_random();
        i_fftshift = 1'($urandom_range(0, 1));
        i_fft_done = 1'b1;
        push_symbol(i_fftshift);
        step();
        i_fft_done = 1'b0;
        chk("b2b_busy", o_busy, 1);
        chk("b2b_valid", o_valid, 0);
        chk("b2b_addr", o_fft_read_addr, 1);
        wait_idle(600);

        // Drop counter saturation with the stream stalled.
        ready_mode = 2;
        fill_random();
        start_capture(1'b0);
        i_fft_done = 1'b1;
        repeat (300) step();
        exp_drop   = sat_inc(exp_drop, 300);
        i_fft_done = 1'b0;
        step();
        chk("drop_sat", o_drop_cnt, exp_drop);

        // Reset mid-stream at beat 10; a done during reset is ignored.
        ready_mode = 0;
        wait_beat(10, 200);
        rst        = 1'b1;
        i_fft_done = 1'b1;
        exp_q.delete();
        step();
        rst        = 1'b0;
        i_fft_done = 1'b0;
        exp_drop   = 0;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_busy", o_busy, 0);
        chk("mid_rst_drop", o_drop_cnt, 0);
        chk("mid_rst_index", o_index, 0);
        chk("mid_rst_re", o_re, 0);
        step();
        chk("rst_done_ignored", o_busy, 0);

        // Full symbol after the abandoned one.
        ready_mode = 1;
        fill_random();
        start_capture(1'($urandom_range(0, 1)));
        wait_idle(2000);
        chk("leftover_beats", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
